// File: rtl/ram_bist_controller.sv
// RAM BIST initiator: fills DEPTH words with an 8-bit LFSR pattern, reads them back and compares.
// Ports: clk/rst (sync, active-high), start/seed request, we/addr/din/dout RAM port, busy/done/pass/fail_cnt/first_fail_addr results.
// Latency start->done 2*DEPTH+READ_LAT+1 (4*DEPTH+2*READ_LAT+1 with BIST_INVERT_PASS_EN); no backpressure, start ignored unless idle.
module ram_bist_controller #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        seed,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        din,
  input  logic [7:0]        dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        fail_cnt,
  output logic [ADDR_W-1:0] first_fail_addr
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [2:0]        LAST_DRAIN = 3'(READ_LAT - 1);

  state_t            state;
  logic [7:0]        seed_q;     // seed with 0 already replaced by 1
  logic [7:0]        pat;        // true LFSR value belonging to the current addr
  logic              inv;        // second (inverted-data) pass in progress
  logic [2:0]        drain_cnt;

  // Delay line aligning each issued read with its returning dout.
  logic [READ_LAT-1:0] dl_vld;
  logic [7:0]          dl_exp  [READ_LAT];
  logic [ADDR_W-1:0]   dl_addr [READ_LAT];

  logic [7:0] pat_nx;
  logic [7:0] seed_eff;
  logic       mism;
  logic [7:0] fail_nx;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    // x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  assign pat_nx   = lfsr_step(pat);
  assign seed_eff = (seed == 8'h00) ? 8'h01 : seed;

  // Failure count including the compare happening at this edge, so the
  // DONE-entry edge can publish pass from the final count.
  always_comb begin
    mism    = dl_vld[READ_LAT-1] && (dout != dl_exp[READ_LAT-1]);
    fail_nx = fail_cnt;
    if (mism && fail_cnt != 8'hFF) fail_nx = fail_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      we              <= 1'b0;
      addr            <= '0;
      din             <= 8'h00;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_cnt        <= 8'h00;
      first_fail_addr <= '0;
      seed_q          <= 8'h00;
      pat             <= 8'h00;
      inv             <= 1'b0;
      drain_cnt       <= 3'd0;
      dl_vld          <= '0;
    end else begin
      dl_vld[0]  <= (state == READ);
      dl_exp[0]  <= inv ? ~pat : pat;
      dl_addr[0] <= addr;
      for (int i = 1; i < READ_LAT; i++) begin
        dl_vld[i]  <= dl_vld[i-1];
        dl_exp[i]  <= dl_exp[i-1];
        dl_addr[i] <= dl_addr[i-1];
      end

      fail_cnt <= fail_nx;
      if (mism && fail_cnt == 8'h00) first_fail_addr <= dl_addr[READ_LAT-1];

      case (state)
        IDLE: begin
          if (start) begin
            seed_q          <= seed_eff;
            pat             <= seed_eff;
            inv             <= 1'b0;
            fail_cnt        <= 8'h00;
            first_fail_addr <= '0;
            pass            <= 1'b0;
            busy            <= 1'b1;
            we              <= 1'b1;
            addr            <= '0;
            din             <= seed_eff;
            state           <= WRITE;
          end
        end
        WRITE: begin
          if (addr == LAST_ADDR) begin
            we    <= 1'b0;
            addr  <= '0;
            din   <= 8'h00;
            pat   <= seed_q;
            state <= READ;
          end else begin
            addr <= addr + ADDR_W'(1);
            pat  <= pat_nx;
            din  <= inv ? ~pat_nx : pat_nx;
          end
        end
        READ: begin
          if (addr == LAST_ADDR) begin
            drain_cnt <= 3'd0;
            state     <= DRAIN;
          end else begin
            addr <= addr + ADDR_W'(1);
            pat  <= pat_nx;
          end
        end
        DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
`ifdef BIST_INVERT_PASS_EN
            if (!inv) begin
              inv   <= 1'b1;
              pat   <= seed_q;
              we    <= 1'b1;
              addr  <= '0;
              din   <= ~seed_q;
              state <= WRITE;
            end else begin
              done  <= 1'b1;
              pass  <= (fail_nx == 8'h00);
              state <= DONE;
            end
`else
            done  <= 1'b1;
            pass  <= (fail_nx == 8'h00);
            state <= DONE;
`endif
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_controller.sv
// Bench for ram_bist_controller: two instances (READ_LAT 1 and 2) beside behavioural RAM models.
// Expected writes and end-of-test results are queued at start; monitors pop and compare on we/done.
// Instance 1 RAM supports a single stuck-at-0 bit fault.
module tb_ram_bist_controller;
  localparam int D = 16;
`ifdef BIST_INVERT_PASS_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start1, start2;
  logic [7:0] seed1, seed2;
  logic       we1, we2, busy1, busy2, done1, done2, pass1, pass2;
  logic [7:0] addr1, addr2, din1, din2, dout1, dout2, fcnt1, fcnt2, ffa1, ffa2;

  ram_bist_controller #(.DEPTH(D), .ADDR_W(8), .READ_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start1), .seed(seed1), .we(we1), .addr(addr1),
    .din(din1), .dout(dout1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_cnt(fcnt1), .first_fail_addr(ffa1));

  ram_bist_controller #(.DEPTH(D), .ADDR_W(8), .READ_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .seed(seed2), .we(we2), .addr(addr2),
    .din(din2), .dout(dout2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_cnt(fcnt2), .first_fail_addr(ffa2));

  // RAM models
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  logic [7:0] rd2a;
  logic       f_en;
  logic [7:0] f_addr;
  logic [2:0] f_bit;

  always @(posedge clk) begin
    if (we1) mem1[addr1] <= (f_en && addr1 == f_addr) ? (din1 & ~(8'h01 << f_bit)) : din1;
    dout1 <= mem1[addr1];
    if (we2) mem2[addr2] <= din2;
    rd2a  <= mem2[addr2];
    dout2 <= rd2a;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string n, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", n, a, e, cyc);
    end
  endtask

  typedef struct {int cyc1; int lat; int pass; int fcnt; int ffa;} res_t;
  res_t exp_q1[$];
  res_t exp_q2[$];
  int   wq[$];
  res_t e1, e2;
  int   w;

  function automatic logic [7:0] step(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  // Whole-test reference: pattern per address, fault applied on store, count diffs.
  function automatic res_t model(input logic [7:0] s, input bit fen, input int fa,
                                 input int fb, input int rl, input int c1);
    res_t r;
    logic [7:0] p, d, st, m;
    r.cyc1 = c1;
    r.lat  = NP * (2 * D + rl) + 1;
    r.fcnt = 0;
    r.ffa  = 0;
    m = 8'(1 << fb);
    for (int ps = 0; ps < NP; ps++) begin
      p = (s == 8'h00) ? 8'h01 : s;
      for (int k = 0; k < D; k++) begin
        d  = (ps != 0) ? ~p : p;
        st = (fen && k == fa) ? (d & ~m) : d;
        if (st != d) begin
          if (r.fcnt == 0) r.ffa = k;
          if (r.fcnt < 255) r.fcnt++;
        end
        p = step(p);
      end
    end
    r.pass = (r.fcnt == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic push_writes(input logic [7:0] s);
    logic [7:0] p;
    for (int ps = 0; ps < NP; ps++) begin
      p = (s == 8'h00) ? 8'h01 : s;
      for (int k = 0; k < D; k++) begin
        wq.push_back((k << 8) | int'((ps != 0) ? ~p : p));
        p = step(p);
      end
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    if (done1) begin
      if (exp_q1.size() == 0) chk("unexpected_done1", 1, 0);
      else begin
        e1 = exp_q1.pop_front();
        chk("latency1", cyc - e1.cyc1 + 1, e1.lat);
        chk("pass1", int'(pass1), e1.pass);
        chk("fail_cnt1", int'(fcnt1), e1.fcnt);
        chk("first_fail_addr1", int'(ffa1), e1.ffa);
      end
    end
    if (we1) begin
      if (wq.size() == 0) chk("extra_write", 1, 0);
      else begin
        w = wq.pop_front();
        chk("wr_addr", int'(addr1), w >> 8);
        chk("wr_din", int'(din1), w & 255);
      end
    end else if (busy1) begin
      chk("din_idle", int'(din1), 0);
    end
    if (done2) begin
      if (exp_q2.size() == 0) chk("unexpected_done2", 1, 0);
      else begin
        e2 = exp_q2.pop_front();
        chk("latency2", cyc - e2.cyc1 + 1, e2.lat);
        chk("pass2", int'(pass2), e2.pass);
        chk("fail_cnt2", int'(fcnt2), e2.fcnt);
      end
    end
  end

  task automatic wait_q1();
    for (int i = 0; i < 400 && exp_q1.size() != 0; i++) @(negedge clk);
    if (exp_q1.size() != 0) begin
      chk("done1_timeout", 0, 1);
      exp_q1.delete();
      wq.delete();
    end
    repeat (3) @(negedge clk);
    chk("writes_left", wq.size(), 0);
    chk("busy1_after", int'(busy1), 0);
  endtask

  task automatic run1(input logic [7:0] s, input bit fen, input int fa, input int fb,
                      input int poke_at);
    @(negedge clk);
    f_en = fen; f_addr = 8'(fa); f_bit = 3'(fb);
    seed1 = s; start1 = 1'b1;
    @(posedge clk); #1;
    exp_q1.push_back(model(s, fen, fa, fb, 1, cyc));
    push_writes(s);
    @(negedge clk);
    start1 = 1'b0;
    if (poke_at > 0) begin
      repeat (poke_at - 1) @(negedge clk);
      seed1 = 8'($urandom); start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
    end
    wait_q1();
  endtask

  task automatic run2(input logic [7:0] s);
    @(negedge clk);
    seed2 = s; start2 = 1'b1;
    @(posedge clk); #1;
    exp_q2.push_back(model(s, 1'b0, 0, 0, 2, cyc));
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 400 && exp_q2.size() != 0; i++) @(negedge clk);
    if (exp_q2.size() != 0) begin
      chk("done2_timeout", 0, 1);
      exp_q2.delete();
    end
  endtask

  logic [7:0] s, p;

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; seed1 = 8'h00; seed2 = 8'h00;
    f_en = 1'b0; f_addr = 8'h00; f_bit = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", int'(we1), 0);
    chk("rst_addr", int'(addr1), 0);
    chk("rst_din", int'(din1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_pass", int'(pass1), 0);
    chk("rst_fail_cnt", int'(fcnt1), 0);
    chk("rst_ffa", int'(ffa1), 0);
    chk("rst_busy2", int'(busy2), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fault-free, seed A5
    run1(8'hA5, 1'b0, 0, 0, 0);

    // Stuck-at-0 on bit 3 of address 9, with a seed whose word 9 has bit 3 set
    s = 8'($urandom);
    for (int t = 0; t < 256; t++) begin
      p = (s == 8'h00) ? 8'h01 : s;
      repeat (9) p = step(p);
      if (p[3]) break;
      s = s + 8'd1;
    end
    run1(s, 1'b1, 9, 3, 0);

    // Random faults and random clean runs
    for (int t = 0; t < 5; t++)
      run1(8'($urandom), 1'b1, int'($urandom_range(0, D - 1)), int'($urandom_range(0, 7)), 0);
    for (int t = 0; t < 3; t++)
      run1(8'($urandom), 1'b0, 0, 0, 0);

    // Seed 0 is replaced by 1
    run1(8'h00, 1'b0, 0, 0, 0);

    // Reset in cycle 5 of WRITE
    @(negedge clk);
    f_en = 1'b0; s = 8'($urandom); seed1 = s; start1 = 1'b1;
    @(posedge clk); #1;
    exp_q1.push_back(model(s, 1'b0, 0, 0, 1, cyc));
    push_writes(s);
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_we", int'(we1), 0);
    chk("midrst_busy", int'(busy1), 0);
    chk("midrst_fail_cnt", int'(fcnt1), 0);
    exp_q1.delete();
    wq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run1(8'($urandom), 1'b0, 0, 0, 0);

    // start pulsed during READ is ignored
    run1(8'($urandom), 1'b0, 0, 0, 20);

    // READ_LAT = 2 instance
    run2(8'($urandom));
    run2(8'h5A);

    repeat (5) @(negedge clk);
    chk("queues_empty", exp_q1.size() + exp_q2.size() + wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
